// File: rtl/polar_fifo_pkg.sv
// Constants and serializer state type shared by the polar-link transmit and receive FIFOs.
package polar_fifo_pkg;
  localparam int BYTE_W     = 8;
  localparam int FIFO_DEPTH = 200;
  localparam int PTR_W      = 9;

  typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_e;

  // Pointer increment that wraps at an arbitrary depth, not at 2^PTR_W
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p, input int depth);
    return (p == PTR_W'(depth - 1)) ? '0 : p + 1'b1;
  endfunction
endpackage

// File: rtl/p2s_shifter.sv
// Shift-register serializer: loads a word, emits it one bit per accepted beat, flags the last bit.
module p2s_shifter
  import polar_fifo_pkg::*;
#(
  parameter int DATA_W    = BYTE_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ser_ready,
  output logic              o_ser_out,
  output logic              o_ser_valid,
  output logic              o_ser_last,
  output logic              o_can_load
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  ser_state_e        r_state, w_state_nxt;
  logic [DATA_W-1:0] r_sh;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_last;

  assign w_last      = (r_state == SER_SHIFT) && (r_cnt == CNT_W'(DATA_W - 1));
  assign o_ser_valid = (r_state == SER_SHIFT);
  assign o_ser_last  = w_last;
  // The top may load either when idle or on the accepted last beat (back-to-back bytes)
  assign o_can_load  = (r_state == SER_IDLE) || (i_ser_ready && w_last);
  assign o_ser_out   = o_ser_valid & (MSB_FIRST ? r_sh[DATA_W-1] : r_sh[0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= SER_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SER_IDLE:  if (i_load) w_state_nxt = SER_SHIFT;
      SER_SHIFT: if (i_ser_ready && w_last) w_state_nxt = i_load ? SER_SHIFT : SER_IDLE;
      default:   w_state_nxt = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sh  <= i_data;
      r_cnt <= '0;
    end else if (o_ser_valid && i_ser_ready && !w_last) begin
      if (MSB_FIRST) r_sh <= {r_sh[DATA_W-2:0], 1'b0};
      else           r_sh <= {1'b0, r_sh[DATA_W-1:1]};
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/parallel_to_serial_fifo_200.sv
// Transmit-side byte FIFO (arbitrary depth) feeding a ready/valid bit serializer.
module parallel_to_serial_fifo_200
  import polar_fifo_pkg::*;
#(
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int DATA_W    = BYTE_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] par_in,
  input  logic              par_valid,
  output logic              par_ready,
  output logic              ser_out,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_last,
  output logic              empty,
  output logic              full,
  output logic [8:0]        count
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [8:0]        r_count, w_count_nxt;
  logic              r_empty, r_full;
  logic              w_push, w_pop, w_can_load;

  assign par_ready = !r_full;
  assign empty     = r_empty;
  assign full      = r_full;
  assign count     = r_count;

  // A full FIFO rejects pushes even when a pop happens in the same cycle
  assign w_push = par_valid && !r_full;
  assign w_pop  = w_can_load && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 9'd1;
      2'b01:   w_count_nxt = r_count - 9'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= par_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr, DEPTH);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr, DEPTH);
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == 9'd0);
      r_full  <= (w_count_nxt == 9'(DEPTH));
    end
  end

  p2s_shifter #(.DATA_W(DATA_W), .MSB_FIRST(MSB_FIRST)) u_shifter (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_load      (w_pop),
    .i_data      (r_mem[r_rd_ptr]),
    .i_ser_ready (ser_ready),
    .o_ser_out   (ser_out),
    .o_ser_valid (ser_valid),
    .o_ser_last  (ser_last),
    .o_can_load  (w_can_load)
  );
endmodule
